// File: rtl/jk_pkg.sv
// Shared types and the JK excitation table for the excitation encoder.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        APPLY  = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Packed as {J, K}.
    typedef logic [1:0] jk_t;

    // Inverse of the JK cell: excitation that takes one bit from q to t.
    function automatic jk_t excite(input logic q, input logic t, input logic xfill);
        jk_t r;
        case ({q, t})
            2'b00:   r = 2'b00;
            2'b01:   r = xfill ? 2'b11 : 2'b10;
            2'b10:   r = xfill ? 2'b11 : 2'b01;
            2'b11:   r = 2'b00;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single edge-triggered JK storage cell with enable and async active-low reset.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK next-state: hold, reset, set, toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/jk_excitation_encoder.sv
// Computes J/K excitation driving a bank of JK cells to a target word,
// applies it, then checks the resulting state against the target.
module jk_excitation_encoder
    import jk_pkg::*;
#(
    parameter int   WIDTH = 4,
    parameter logic XFILL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             hold,
    input  logic             err_clr,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             err,
    output logic [15:0]      chg_cnt
);

    state_t           state_r;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] exc_j_s;
    logic [WIDTH-1:0] exc_k_s;
    logic [WIDTH-1:0] q_next_s;
    logic [4:0]       pop_s;
    logic [16:0]      sum_s;
    logic [15:0]      cnt_next_s;
    logic             cell_en_s;

    assign tgt_ready = (state_r == IDLE);
    assign cell_en_s = (state_r == APPLY) && !hold;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .en  (cell_en_s),
                .j   (j[gi]),
                .k   (k[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

    // Per-bit excitation from the live bank state and the captured target.
    always_comb begin
        exc_j_s = '0;
        exc_k_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {exc_j_s[i], exc_k_s[i]} = excite(q[i], tgt_r[i], XFILL);
        end
    end

    // Predicted bank state after APPLY, used only to count changed bits.
    always_comb begin
        q_next_s = q;
        pop_s    = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cell_en_s) begin
                case ({j[i], k[i]})
                    2'b00:   q_next_s[i] = q[i];
                    2'b01:   q_next_s[i] = 1'b0;
                    2'b10:   q_next_s[i] = 1'b1;
                    2'b11:   q_next_s[i] = ~q[i];
                    default: q_next_s[i] = q[i];
                endcase
            end else begin
                q_next_s[i] = q[i];
            end
            pop_s = pop_s + {4'd0, q[i] ^ q_next_s[i]};
        end
    end

    // Saturating add of the changed-bit count.
    always_comb begin
        sum_s = {1'b0, chg_cnt} + {12'd0, pop_s};
        if (sum_s[16]) begin
            cnt_next_s = 16'hFFFF;
        end else begin
            cnt_next_s = sum_s[15:0];
        end
    end

    // Control FSM with registered excitation, status and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            tgt_r   <= '0;
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            chg_cnt <= 16'd0;
        end else begin
            done <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_r   <= tgt_data;
                        state_r <= ENCODE;
                    end
                end
                ENCODE: begin
                    j       <= exc_j_s;
                    k       <= exc_k_s;
                    state_r <= APPLY;
                end
                APPLY: begin
                    chg_cnt <= cnt_next_s;
                    state_r <= CHECK;
                end
                CHECK: begin
                    // A fresh mismatch overrides a simultaneous err_clr.
                    if (q != tgt_r) begin
                        err <= 1'b1;
                    end
                    done    <= 1'b1;
                    j       <= '0;
                    k       <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    j       <= '0;
                    k       <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
